// File: rtl/ntt_ctrl.sv
// NTT/INVNTT butterfly sequencer: walks the layer/index schedule, drives
// coefficient RAM and zeta ROM read addresses, and replays each issued
// address pair through a delay line so write-back lines up with the
// butterfly output.
// Optional build macro: NTT_CTRL_PERF_CNT_EN enables the busy-cycle counter
// on cycle_cnt; without it cycle_cnt is tied to zero.
module ntt_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_u,
  output logic [7:0] rd_addr_t,
  output logic [6:0] zeta_idx,
  output logic [1:0] bu_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_u,
  output logic [7:0] wr_addr_t,
  output logic [15:0] cycle_cnt
);

  localparam int MAX_D = RD_LAT + 5;
  localparam int TAP_W = $clog2(MAX_D);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  layer_q, layer_d;
  logic [16:0] dly_q [MAX_D];
  logic [16:0] dly_d [MAX_D];

  int               bf_lat;
  logic [7:0]       drain_last;
  logic [TAP_W-1:0] tap;
  logic             last_issue;
  logic [2:0]       lg;
  logic [7:0]       len, g, j, m;
  logic [7:0]       addr_u, addr_t;
  logic [6:0]       zeta;

  assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign rd_en   = (state_q == ISSUE);
  assign bu_mode = busy ? op_q : 2'd0;

  assign rd_addr_u = rd_en ? addr_u : 8'd0;
  assign rd_addr_t = rd_en ? addr_t : 8'd0;
  assign zeta_idx  = rd_en ? zeta : 7'd0;

  assign last_issue = op_q[1] ? (cnt_q == 8'd255) : (cnt_q == 8'd127);

  // Write delay D = read latency + butterfly latency; pick drain length and delay-line tap
  always_comb begin
    bf_lat = 1;
    case (op_q)
      2'd0, 2'd1: bf_lat = 5;
      2'd2:       bf_lat = 4;
      default:    bf_lat = 1;
    endcase
    drain_last = 8'(RD_LAT + bf_lat - 1);
    tap        = TAP_W'(RD_LAT + bf_lat - 1);
  end

  // Address and twiddle generation for the current issue index and layer
  always_comb begin
    lg     = 3'd0;
    len    = 8'd0;
    g      = 8'd0;
    j      = 8'd0;
    m      = 8'd0;
    addr_u = 8'd0;
    addr_t = 8'd0;
    zeta   = 7'd0;
    if (op_q[1]) begin
      addr_u = cnt_q;
      addr_t = cnt_q;
      zeta   = op_q[0] ? 7'd0 : 7'd64 + {1'b0, cnt_q[7:2]};
    end else begin
      lg     = op_q[0] ? layer_q + 3'd1 : 3'd7 - layer_q;
      len    = 8'd1 << lg;
      g      = {1'b0, cnt_q[6:0]} >> lg;
      j      = (g << ({1'b0, lg} + 4'd1)) | ({1'b0, cnt_q[6:0]} & (len - 8'd1));
      m      = 8'd1 << (3'd7 - lg);
      addr_u = j;
      addr_t = j + len;
      zeta   = op_q[0] ? 7'((m << 1) - 8'd1 - g) : 7'(m + g);
    end
  end

  // Sequencer: issue a full pass, drain until its last write lands, repeat per layer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          op_d    = op;
          cnt_d   = 8'd0;
          layer_d = 3'd0;
        end
      end
      ISSUE: begin
        if (last_issue) begin
          cnt_d   = 8'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == drain_last) begin
          cnt_d = 8'd0;
          if (op_q[1] || (layer_q == 3'd6)) begin
            state_d = DONE;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Delay line shifts issued address pairs; flushed while idle so no stale entry survives a new op
  always_comb begin
    for (int k = 0; k < MAX_D; k++) dly_d[k] = '0;
    if (state_q != IDLE) begin
      dly_d[0] = {rd_en, rd_addr_u, rd_addr_t};
      for (int k = 1; k < MAX_D; k++) dly_d[k] = dly_q[k-1];
    end
  end

  assign wr_en     = dly_q[tap][16];
  assign wr_addr_u = dly_q[tap][15:8];
  assign wr_addr_t = dly_q[tap][7:0];

  // State, counters, latched op and delay line registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      cnt_q   <= 8'd0;
      layer_q <= 3'd0;
      for (int k = 0; k < MAX_D; k++) dly_q[k] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      layer_q <= layer_d;
      for (int k = 0; k < MAX_D; k++) dly_q[k] <= dly_d[k];
    end
  end

`ifdef NTT_CTRL_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Busy-cycle counter: restarts on an accepted start, holds after completion
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == IDLE) && start) begin
      cyc_d = 16'd0;
    end else if (busy) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Busy-cycle counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= 16'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: an independent schedule model predicts
// every issue; the expected write-backs go into a scoreboard queue and are
// matched against the DUT write port cycle by cycle.
module tb_ntt_ctrl;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr_u, rd_addr_t, wr_addr_u, wr_addr_t;
  logic [6:0]  zeta_idx;
  logic [1:0]  bu_mode;
  logic [15:0] cycle_cnt;

  typedef struct {
    int cyc;
    int u;
    int t;
  } wr_exp_t;

  wr_exp_t wrQ[$];
  int errors = 0;
  int checks = 0;

  ntt_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .rd_addr_u(rd_addr_u),
    .rd_addr_t(rd_addr_t),
    .zeta_idx(zeta_idx),
    .bu_mode(bu_mode),
    .wr_en(wr_en),
    .wr_addr_u(wr_addr_u),
    .wr_addr_t(wr_addr_t),
    .cycle_cnt(cycle_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference schedule: operand addresses and zeta index for pass p, step b
  function automatic void modelIssue(input int opIn, input int p, input int b,
                                     output int u, output int t, output int z);
    int len, g, j, m;
    if (opIn >= 2) begin
      u = b;
      t = b;
      z = (opIn == 2) ? 64 + b / 4 : 0;
    end else begin
      len = (opIn == 0) ? 128 / (2 ** p) : 2 * (2 ** p);
      g   = b / len;
      j   = g * 2 * len + b % len;
      m   = 128 / len;
      u   = j;
      t   = j + len;
      z   = (opIn == 0) ? m + g : 2 * m - 1 - g;
    end
  endfunction

  // All outputs idle
  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 0);
    checkOutput({tag, "_bu_mode"}, 32'(bu_mode), 0);
  endtask

  // Run one operation; optionally pulse an illegal start or reset mid-run
  task automatic applyStimulus(input int opIn, input int abortAt, input int ignoreAt);
    int lat, d, n, passes, total, p, r, u, t, z;
    bit aborted;
    wr_exp_t e;
    lat    = (opIn <= 1) ? 5 : (opIn == 2) ? 4 : 1;
    d      = RD_LAT + lat;
    n      = (opIn <= 1) ? 128 : 256;
    passes = (opIn <= 1) ? 7 : 1;
    total  = passes * (n + d);
    aborted = 1'b0;
    wrQ.delete();
    @(negedge clk);
    start = 1'b1;
    op    = 2'(opIn);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      p = (c - 1) / (n + d);
      r = (c - 1) % (n + d);
      if ((c <= total) && (r < n)) begin
        modelIssue(opIn, p, r, u, t, z);
        checkOutput("rd_en", 32'(rd_en), 1);
        checkOutput("rd_addr_u", 32'(rd_addr_u), u);
        checkOutput("rd_addr_t", 32'(rd_addr_t), t);
        checkOutput("zeta_idx", 32'(zeta_idx), z);
        e.cyc = c + d;
        e.u   = u;
        e.t   = t;
        wrQ.push_back(e);
      end else begin
        checkOutput("rd_en_quiet", 32'(rd_en), 0);
      end
      if ((wrQ.size() > 0) && (wrQ[0].cyc == c)) begin
        e = wrQ.pop_front();
        checkOutput("wr_en", 32'(wr_en), 1);
        checkOutput("wr_addr_u", 32'(wr_addr_u), e.u);
        checkOutput("wr_addr_t", 32'(wr_addr_t), e.t);
      end else begin
        checkOutput("wr_en_quiet", 32'(wr_en), 0);
      end
      checkOutput("busy", 32'(busy), (c <= total) ? 1 : 0);
      checkOutput("done", 32'(done), (c == total + 1) ? 1 : 0);
      checkOutput("bu_mode", 32'(bu_mode), (c <= total) ? opIn : 0);
      if (c == ignoreAt) begin
        start = 1'b1;
        op    = 2'd3;
      end else if ((ignoreAt > 0) && (c == ignoreAt + 1)) begin
        start = 1'b0;
      end
      if (c == abortAt) begin
        rst_n = 1'b0;
        @(negedge clk);
        checkQuiet("abort");
        checkOutput("abort_cycle_cnt", 32'(cycle_cnt), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkQuiet("post_abort");
        end
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) checkOutput("wr_queue_empty", 32'(wrQ.size()), 0);
    op = 2'd0;
  endtask

  // Directed sequence: reset, each op, ignored start, mid-run reset, rerun
  initial begin
    int perfExp;
`ifdef NTT_CTRL_PERF_CNT_EN
    perfExp = 938;
`else
    perfExp = 0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset_rd_addr_u", 32'(rd_addr_u), 0);
    checkOutput("reset_zeta", 32'(zeta_idx), 0);
    checkOutput("reset_cycle_cnt", 32'(cycle_cnt), 0);
    rst_n = 1'b1;

    $display("[TB] op=0 NTT");
    applyStimulus(0, 0, 0);
    checkOutput("cycle_cnt_ntt", 32'(cycle_cnt), perfExp);

    $display("[TB] op=1 INVNTT");
    applyStimulus(1, 0, 0);

    $display("[TB] op=2 with ignored start");
    applyStimulus(2, 0, 10);

    $display("[TB] op=3 add/sub");
    applyStimulus(3, 0, 0);

    $display("[TB] op=0 reset at busy cycle 300");
    applyStimulus(0, 300, 0);

    $display("[TB] op=0 rerun after reset");
    applyStimulus(0, 0, 0);
    checkOutput("cycle_cnt_rerun", 32'(cycle_cnt), perfExp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
